// File: rtl/mcu_block_sequencer_if.sv
// Handshake and data bundle between the IDCT output, the block sequencer and the
// supersample stage. The bench or upstream logic takes the master side.
interface mcu_block_sequencer_if #(
    parameter int MCU_W = 16,
    parameter int CH    = 3
);
    localparam int CH_W = $clog2(CH + 1);

    logic                          start;
    logic                          mode_420;
    logic [MCU_W-1:0]              num_mcu;
    logic                          in_valid;
    logic                          in_ready;
    logic signed [7:0][7:0][8:0]   in_block;
    logic                          ds_ready;
    logic                          ss_valid;
    logic [CH_W-1:0]               ss_ch;
    logic [1:0]                    ss_yidx;
    logic signed [7:0][7:0][8:0]   ss_block;
    logic                          mcu_done;
    logic                          frame_done;
    logic                          busy;

    modport master (
        output start, mode_420, num_mcu, in_valid, in_block, ds_ready,
        input  in_ready, ss_valid, ss_ch, ss_yidx, ss_block, mcu_done, frame_done, busy
    );

    modport slave (
        input  start, mode_420, num_mcu, in_valid, in_block, ds_ready,
        output in_ready, ss_valid, ss_ch, ss_yidx, ss_block, mcu_done, frame_done, busy
    );
endinterface

// File: rtl/mcu_block_sequencer.sv
// Tags IDCT blocks with channel / Y-quadrant in MCU order and forwards them one at a
// time through a single-entry hold register whenever the colour buffer can take one.
module mcu_block_sequencer #(
    parameter int MCU_W = 16,
    parameter int CH    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    mcu_block_sequencer_if.slave  sq
);
    localparam int CH_W = $clog2(CH + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]                  state_reg;
    logic                        mode_reg;
    logic [MCU_W-1:0]            num_reg;
    logic [2:0]                  pos_reg;
    logic [MCU_W-1:0]            acc_cnt_reg;
    logic [MCU_W-1:0]            mcu_cnt_reg;

    logic                        hold_valid_reg;
    logic signed [7:0][7:0][8:0] hold_block_reg;
    logic [CH_W-1:0]             hold_ch_reg;
    logic [1:0]                  hold_yidx_reg;
    logic                        hold_last_reg;

    logic                        ss_valid_reg;
    logic [CH_W-1:0]             ss_ch_reg;
    logic [1:0]                  ss_yidx_reg;
    logic signed [7:0][7:0][8:0] ss_block_reg;
    logic                        mcu_done_reg;

    logic                        in_ready;
    logic                        accept;
    logic                        issue;
    logic                        at_last;
    logic                        final_accept;
    logic [CH_W-1:0]             tag_ch;
    logic [1:0]                  tag_yidx;

    always_comb begin
        at_last  = (pos_reg == (mode_reg ? 3'd5 : 3'd2));
        tag_ch   = '0;
        tag_yidx = 2'd0;
        if (mode_reg) begin
            if (pos_reg < 3'd4) begin
                tag_yidx = pos_reg[1:0];
            end else if (pos_reg == 3'd4) begin
                tag_ch = CH_W'(1);
            end else begin
                tag_ch = CH_W'(2);
            end
        end else begin
            tag_ch = CH_W'(pos_reg);
        end
    end

    assign in_ready     = (state_reg == ST_RUN) && (!hold_valid_reg || sq.ds_ready);
    assign accept       = sq.in_valid && in_ready;
    assign issue        = hold_valid_reg && sq.ds_ready &&
                          ((state_reg == ST_RUN) || (state_reg == ST_DRAIN));
    // acc_cnt counts fully accepted MCUs, so the last block of the frame is the
    // last position of MCU num-1.
    assign final_accept = accept && at_last && (acc_cnt_reg == num_reg - MCU_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            mode_reg    <= 1'b0;
            num_reg     <= '0;
            pos_reg     <= 3'd0;
            acc_cnt_reg <= '0;
            mcu_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (sq.start) begin
                        mode_reg    <= sq.mode_420;
                        num_reg     <= sq.num_mcu;
                        pos_reg     <= 3'd0;
                        acc_cnt_reg <= '0;
                        mcu_cnt_reg <= '0;
                        state_reg   <= (sq.num_mcu == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (final_accept) begin
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!hold_valid_reg && (mcu_cnt_reg == num_reg)) begin
                        state_reg <= ST_DONE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase

            if (accept) begin
                pos_reg <= at_last ? 3'd0 : pos_reg + 3'd1;
                if (at_last) begin
                    acc_cnt_reg <= acc_cnt_reg + MCU_W'(1);
                end
            end
            if (issue && hold_last_reg) begin
                mcu_cnt_reg <= mcu_cnt_reg + MCU_W'(1);
            end
        end
    end

    // A same-cycle accept overwrites the entry that is issuing, keeping it full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid_reg <= 1'b0;
            hold_block_reg <= '0;
            hold_ch_reg    <= '0;
            hold_yidx_reg  <= 2'd0;
            hold_last_reg  <= 1'b0;
        end else if (accept) begin
            hold_valid_reg <= 1'b1;
            hold_block_reg <= sq.in_block;
            hold_ch_reg    <= tag_ch;
            hold_yidx_reg  <= tag_yidx;
            hold_last_reg  <= at_last;
        end else if (issue) begin
            hold_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_valid_reg <= 1'b0;
            ss_ch_reg    <= '0;
            ss_yidx_reg  <= 2'd0;
            ss_block_reg <= '0;
            mcu_done_reg <= 1'b0;
        end else begin
            ss_valid_reg <= issue;
            mcu_done_reg <= issue && hold_last_reg;
            if (issue) begin
                ss_ch_reg    <= hold_ch_reg;
                ss_yidx_reg  <= hold_yidx_reg;
                ss_block_reg <= hold_block_reg;
            end
        end
    end

    assign sq.in_ready   = in_ready;
    assign sq.ss_valid   = ss_valid_reg;
    assign sq.ss_ch      = ss_ch_reg;
    assign sq.ss_yidx    = ss_yidx_reg;
    assign sq.ss_block   = ss_block_reg;
    assign sq.mcu_done   = mcu_done_reg;
    assign sq.frame_done = (state_reg == ST_DONE);
    assign sq.busy       = (state_reg != ST_IDLE);
endmodule

// File: tb/tb_mcu_block_sequencer.sv
// Randomized bench for mcu_block_sequencer: every accepted block is tagged by a
// position-in-MCU model and must reappear, in order, on the supersample side.
module tb_mcu_block_sequencer;
    logic clk = 1'b0;
    logic rst;

    mcu_block_sequencer_if #(.MCU_W(16), .CH(3)) bus ();

    mcu_block_sequencer #(.MCU_W(16), .CH(3)) dut (
        .clk (clk),
        .rst (rst),
        .sq  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   ch;
        logic [1:0]   yidx;
        logic         last;
        logic [575:0] blk;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_md_cyc = 0;
    int   issue_cnt = 0;
    int   md_cnt = 0;
    int   acc_k = 0;
    bit   mode_g = 1'b0;
    bit   exact_fd = 1'b0;

    task automatic check(input string tag, input logic [575:0] got, input logic [575:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [575:0] rand_blk(input int seq);
        logic [575:0] b;
        for (int i = 0; i < 18; i++) b[i*32 +: 32] = $urandom;
        b[8:0] = 9'(seq);
        return b;
    endfunction

    // Tag expected for the k-th block of a frame, straight from the sampling layout.
    function automatic exp_t model_tag(input int k, input bit m, input logic [575:0] b);
        exp_t r;
        int bpm = m ? 6 : 3;
        int p = k % bpm;
        if (m) begin
            r.ch   = (p < 4) ? 2'd0 : 2'(p - 3);
            r.yidx = (p < 4) ? 2'(p) : 2'd0;
        end else begin
            r.ch   = 2'(p);
            r.yidx = 2'd0;
        end
        r.last = (p == bpm - 1);
        r.blk  = b;
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ss_valid) begin
                if (expq.size() == 0) begin
                    check("spurious_issue", 1, 0);
                end else begin
                    mon_e = expq.pop_front();
                    check("ss_ch", bus.ss_ch, mon_e.ch);
                    check("ss_yidx", bus.ss_yidx, mon_e.yidx);
                    check("ss_block", bus.ss_block, mon_e.blk);
                    check("mcu_done", bus.mcu_done, mon_e.last);
                end
                issue_cnt++;
                if (bus.mcu_done) begin
                    md_cnt++;
                    last_md_cyc = cyc;
                end
            end
            check("md_align", bus.mcu_done & ~bus.ss_valid, 0);
            if (bus.frame_done) begin
                check("fd_vs_md", bus.mcu_done, 0);
                check("fd_pending", expq.size(), 0);
                if (exact_fd) check("fd_gap", cyc - last_md_cyc, 1);
            end
        end
        cyc++;
    end

    // Called at posedge+1; leaves the bench at posedge+1 of the next cycle.
    task automatic drive_cycle(input bit v, input logic [575:0] b, input bit r, output bit acc);
        bus.in_valid = v;
        bus.in_block = b;
        bus.ds_ready = r;
        bus.mode_420 = 1'($urandom);
        bus.num_mcu  = 16'($urandom);
        @(negedge clk);
        acc = v && bus.in_ready;
        if (acc) begin
            expq.push_back(model_tag(acc_k, mode_g, b));
            acc_k++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input bit m, input int n);
        bus.start    = 1'b1;
        bus.mode_420 = m;
        bus.num_mcu  = 16'(n);
        mode_g       = m;
        acc_k        = 0;
        issue_cnt    = 0;
        md_cnt       = 0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic finish_frame(input int total, input int n, input int rp);
        bit fd = 1'b0;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 2000 && !fd; i++) begin
            bus.ds_ready = (int'($urandom_range(99)) < rp);
            @(negedge clk);
            fd = bus.frame_done;
            if (!fd) begin
                @(posedge clk);
                #1;
            end
        end
        bus.ds_ready = 1'b1;
        check("frame_done_seen", fd, 1);
        check("issue_count", issue_cnt, total);
        check("mcu_done_count", md_cnt, n);
        @(posedge clk);
        #1;
        check("busy_after_done", bus.busy, 0);
        check("fd_one_cycle", bus.frame_done, 0);
    endtask

    task automatic run_frame(input bit m, input int n, input int vp, input int rp,
                             input bit exact, input bit inject);
        int total = n * (m ? 6 : 3);
        int guard = 0;
        bit acc;
        logic [575:0] blk = rand_blk(0);
        exact_fd = exact;
        start_frame(m, n);
        while (acc_k < total && guard < 20000) begin
            bus.start = inject && (acc_k >= 2) && (acc_k <= 3);
            drive_cycle(int'($urandom_range(99)) < vp, blk, int'($urandom_range(99)) < rp, acc);
            if (acc) blk = rand_blk(acc_k);
            guard++;
        end
        bus.start = 1'b0;
        check("accept_count", acc_k, total);
        finish_frame(total, n, rp);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        bit acc;
        logic [575:0] b;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.mode_420 = 1'b0;
        bus.num_mcu  = '0;
        bus.in_valid = 1'b0;
        bus.in_block = '0;
        bus.ds_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_ss_valid", bus.ss_valid, 0);
        check("rst_ss_ch", bus.ss_ch, 0);
        check("rst_ss_yidx", bus.ss_yidx, 0);
        check("rst_ss_block", bus.ss_block, 0);
        check("rst_mcu_done", bus.mcu_done, 0);
        check("rst_frame_done", bus.frame_done, 0);
        check("rst_busy", bus.busy, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 4:2:0 at full rate, then 4:4:4 with input gaps
        run_frame(1'b1, 2, 100, 100, 1'b1, 1'b0);
        run_frame(1'b0, 3, 60, 100, 1'b0, 1'b0);

        // downstream stall with a full hold register
        exact_fd = 1'b0;
        start_frame(1'b0, 1);
        drive_cycle(1'b1, rand_blk(100), 1'b0, acc);
        check("stall_first_accept", acc, 1);
        b = rand_blk(101);
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, b, 1'b0, acc);
            check("stall_in_ready", acc, 0);
            check("stall_no_valid", bus.ss_valid, 0);
        end
        drive_cycle(1'b1, b, 1'b1, acc);
        check("stall_release_accept", acc, 1);
        check("stall_release_issue", bus.ss_valid, 1);
        drive_cycle(1'b1, rand_blk(102), 1'b1, acc);
        check("stall_third_accept", acc, 1);
        finish_frame(3, 1, 100);

        // empty frame
        exact_fd = 1'b0;
        start_frame(1'b1, 0);
        check("empty_busy", bus.busy, 1);
        check("empty_frame_done", bus.frame_done, 1);
        check("empty_ss_valid", bus.ss_valid, 0);
        @(posedge clk);
        #1;
        check("empty_busy_after", bus.busy, 0);
        check("empty_fd_after", bus.frame_done, 0);
        check("empty_issue_count", issue_cnt, 0);

        // start pulses during RUN must not disturb the frame
        run_frame(1'b1, 3, 70, 70, 1'b0, 1'b1);

        // reset mid-frame after three accepts
        exact_fd = 1'b0;
        start_frame(1'b1, 2);
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, rand_blk(200 + i), 1'b1, acc);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_in_ready", bus.in_ready, 0);
        check("midrst_ss_valid", bus.ss_valid, 0);
        check("midrst_ss_ch", bus.ss_ch, 0);
        check("midrst_ss_yidx", bus.ss_yidx, 0);
        check("midrst_ss_block", bus.ss_block, 0);
        check("midrst_mcu_done", bus.mcu_done, 0);
        check("midrst_busy", bus.busy, 0);
        expq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_frame(1'b1, 1, 100, 100, 1'b1, 1'b0);

        // back-to-back frames, start in the first IDLE cycle
        run_frame(1'b1, 2, 100, 100, 1'b1, 1'b0);
        run_frame(1'b1, 2, 100, 100, 1'b1, 1'b0);

        for (int i = 0; i < 4; i++) begin
            run_frame(1'($urandom), 1 + int'($urandom_range(3)),
                      40 + int'($urandom_range(60)), 40 + int'($urandom_range(60)),
                      1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
